// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game core.
//   state_t   : top-level game state encoding (IDLE / PLAY / OVER)
//   LFSR_TAPS : Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
//   popcount  : counts set bits of a 16-bit vector; also used by the
//               score/display logic
package whack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Galois LFSR that supplies the random mole patterns.
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset, loads SEED
//   en    in   advance enable
//   out   out  current LFSR state
module mole_lfsr
    import whack_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] out
);

    // Right-shifting Galois form: the bit shifted out feeds back into the
    // tap positions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= SEED;
        end else if (en) begin
            out <= {1'b0, out[15:1]} ^ (out[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/whack_engine.sv
// Whack-a-mole game core. Lights a random subset of moles each game tick,
// scores switch toggles on lit moles, counts unhit moles as misses and
// shortens the tick period as the level rises. Single clock, enables only.
//   clk, rst_n  system clock, asynchronous active-low reset
//   start       1-cycle pulse, starts a game from IDLE or OVER
//   sw          debounced switches, one per mole
//   moles       lit moles (LED drive)
//   score       saturating hit count
//   level       current level, 1..N_LEVELS
//   misses      miss count, saturates at MISS_LIMIT
//   running     high in PLAY
//   game_over   high in OVER
//   tick        1-cycle pulse on every game-tick boundary in PLAY
module whack_engine
    import whack_pkg::*;
#(
    parameter int          N_MOLES    = 8,
    parameter int          SCORE_W    = 8,
    parameter int          LEVEL_STEP = 10,
    parameter int          N_LEVELS   = 7,
    parameter int          BASE_TICKS = 50_000_000,
    parameter int          TICK_DEC   = 5_000_000,
    parameter int          MISS_LIMIT = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_MOLES-1:0] sw,
    output logic [N_MOLES-1:0] moles,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         level,
    output logic [4:0]         misses,
    output logic               running,
    output logic               game_over,
    output logic               tick
);

    localparam int PC_W   = $clog2(N_MOLES + 1);
    localparam int CNT_W  = $clog2(BASE_TICKS);
    // Holds up to LEVEL_STEP-1 carried over plus one full set of hits.
    localparam int STEP_W = $clog2(LEVEL_STEP + N_MOLES);

    state_t             state;
    logic [N_MOLES-1:0] sw_q;
    logic [CNT_W-1:0]   tick_cnt;
    logic [STEP_W-1:0]  step;
    logic [15:0]        lfsr;

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .out   (lfsr)
    );

    logic [N_MOLES-1:0] pattern;
    logic [N_MOLES-1:0] hit;
    logic [N_MOLES-1:0] moles_left;
    logic [PC_W-1:0]    hit_cnt;
    logic [PC_W-1:0]    left_cnt;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_next;
    logic [STEP_W-1:0]  step_sum;
    logic [STEP_W-1:0]  step_next;
    logic               level_up;
    logic [2:0]         level_next;
    logic [5:0]         miss_sum;
    logic [4:0]         miss_next;
    logic               miss_end;
    logic [CNT_W-1:0]   reload;

    always_comb begin
        // An empty board would be a free tick, so force one mole on.
        pattern    = (lfsr[N_MOLES-1:0] == '0) ? N_MOLES'(1) : lfsr[N_MOLES-1:0];
        hit        = (state == ST_PLAY) ? ((sw ^ sw_q) & moles) : '0;
        moles_left = moles & ~hit;
        hit_cnt    = PC_W'(popcount(16'(hit)));
        left_cnt   = PC_W'(popcount(16'(moles_left)));

        score_sum  = {1'b0, score} + (SCORE_W+1)'(hit_cnt);
        score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

        step_sum   = step + STEP_W'(hit_cnt);
        level_up   = (step_sum >= STEP_W'(LEVEL_STEP));
        step_next  = level_up ? (step_sum - STEP_W'(LEVEL_STEP)) : step_sum;
        level_next = (level_up && (level < 3'(N_LEVELS))) ? (level + 3'd1) : level;

        // Misses are charged only for moles still lit after this cycle's hits.
        miss_sum   = {1'b0, misses} + 6'(left_cnt);
        miss_end   = (miss_sum >= 6'(MISS_LIMIT));
        miss_next  = miss_end ? 5'(MISS_LIMIT) : miss_sum[4:0];

        // Period follows the post-level-up level so a new level's speed
        // applies from the very tick it was reached on.
        reload     = CNT_W'(BASE_TICKS - 1 - (int'(level_next) - 1) * TICK_DEC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sw_q      <= '0;
            tick_cnt  <= '0;
            step      <= '0;
            moles     <= '0;
            score     <= '0;
            level     <= 3'd1;
            misses    <= '0;
            running   <= 1'b0;
            game_over <= 1'b0;
            tick      <= 1'b0;
        end else begin
            sw_q <= sw;
            tick <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state     <= ST_PLAY;
                        running   <= 1'b1;
                        game_over <= 1'b0;
                        score     <= '0;
                        misses    <= '0;
                        step      <= '0;
                        level     <= 3'd1;
                        tick_cnt  <= CNT_W'(BASE_TICKS - 1);
                        moles     <= pattern;
                    end
                end
                ST_PLAY: begin
                    score <= score_next;
                    step  <= step_next;
                    level <= level_next;
                    if (tick_cnt == '0) begin
                        tick     <= 1'b1;
                        tick_cnt <= reload;
                        misses   <= miss_next;
                        if (miss_end) begin
                            state     <= ST_OVER;
                            moles     <= '0;
                            running   <= 1'b0;
                            game_over <= 1'b1;
                        end else begin
                            moles <= pattern;
                        end
                    end else begin
                        tick_cnt <= tick_cnt - CNT_W'(1);
                        moles    <= moles_left;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_whack_engine.sv
module tb_whack_engine;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] sw;
    logic [7:0] moles;
    logic [7:0] score;
    logic [2:0] level;
    logic [4:0] misses;
    logic       running;
    logic       game_over;
    logic       tick;

    whack_engine #(
        .N_MOLES    (8),
        .SCORE_W    (8),
        .LEVEL_STEP (10),
        .N_LEVELS   (7),
        .BASE_TICKS (20),
        .TICK_DEC   (2),
        .MISS_LIMIT (4),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sw        (sw),
        .moles     (moles),
        .score     (score),
        .level     (level),
        .misses    (misses),
        .running   (running),
        .game_over (game_over),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting Galois form.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    int         n_chk = 0;
    int         n_err = 0;
    int         since = 0;
    int         period = 0;
    logic [7:0] cur_pat = 8'h00;
    logic [7:0] exp_moles = 8'h00;
    int         exp_score = 0;
    int         exp_step = 0;
    int         exp_level = 1;
    int         exp_miss = 0;
    int         tick_level = 1;
    bit         over = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fix_pat(input logic [7:0] v);
        return (v == 8'h00) ? 8'h01 : v;
    endfunction

    // One clock; remembers the pattern a load on this edge would use and
    // measures the spacing of tick pulses.
    task automatic cyc();
        logic [7:0] p;
        p = fix_pat(m_lfsr[7:0]);
        @(posedge clk);
        #1;
        since++;
        cur_pat = p;
        if (tick) begin
            period = since;
            since  = 0;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_moles"},  32'(moles),     0);
        chk({tag, "_score"},  32'(score),     0);
        chk({tag, "_level"},  32'(level),     1);
        chk({tag, "_misses"}, 32'(misses),    0);
        chk({tag, "_run"},    32'(running),   0);
        chk({tag, "_over"},   32'(game_over), 0);
        chk({tag, "_tick"},   32'(tick),      0);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        cyc();
        start      = 1'b0;
        since      = 0;
        exp_moles  = cur_pat;
        exp_score  = 0;
        exp_step   = 0;
        exp_level  = 1;
        exp_miss   = 0;
        tick_level = 1;
        over       = 1'b0;
        chk({tag, "_run"},    32'(running),   1);
        chk({tag, "_over"},   32'(game_over), 0);
        chk({tag, "_level"},  32'(level),     1);
        chk({tag, "_score"},  32'(score),     0);
        chk({tag, "_misses"}, 32'(misses),    0);
        chk({tag, "_moles"},  32'(moles),     32'(cur_pat));
        chk({tag, "_nz"},     32'(moles != 8'h00), 1);
    endtask

    // Bookkeeping for n hits landing on one edge.
    task automatic add_hits(input int n);
        exp_score = (exp_score + n > 255) ? 255 : exp_score + n;
        exp_step += n;
        if (exp_step >= 10) begin
            exp_step -= 10;
            if (exp_level < 7) exp_level++;
        end
    endtask

    // Toggle every currently lit mole in one (non-tick) cycle.
    task automatic whack();
        int n;
        n  = $countones(exp_moles);
        sw = sw ^ exp_moles;
        cyc();
        add_hits(n);
        exp_moles = 8'h00;
        chk("whack_score", 32'(score), 32'(exp_score));
        chk("whack_level", 32'(level), 32'(exp_level));
        chk("whack_moles", 32'(moles), 0);
    endtask

    // Idle until the next tick, then check period, misses and new board.
    task automatic to_tick(input string tag);
        int exp_per;
        bit got;
        exp_per = 20 - 2 * (tick_level - 1);
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            cyc();
            if (tick) got = 1'b1;
        end
        if (!got) chk({tag, "_timeout"}, 0, 1);
        chk({tag, "_period"}, 32'(period), 32'(exp_per));
        exp_miss += $countones(exp_moles);
        if (exp_miss > 4) exp_miss = 4;
        chk({tag, "_misses"}, 32'(misses), 32'(exp_miss));
        tick_level = exp_level;
        if (exp_miss >= 4) begin
            over      = 1'b1;
            exp_moles = 8'h00;
            chk({tag, "_end_moles"}, 32'(moles),     0);
            chk({tag, "_end_over"},  32'(game_over), 1);
            chk({tag, "_end_run"},   32'(running),   0);
        end else begin
            exp_moles = cur_pat;
            chk({tag, "_moles"}, 32'(moles), 32'(cur_pat));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  i0;
        int  n;
        int  cnt7;
        int  pre;
        bit  done;

        rst_n = 1'b0;
        start = 1'b0;
        sw    = 8'h00;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_reset("rst");
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("idle_run", 32'(running), 0);

        // Start and first board
        do_start("start");

        // Single hit, then a repeat toggle in the same tick
        i0 = 0;
        for (int b = 7; b >= 0; b--) if (exp_moles[b]) i0 = b;
        sw[i0] = ~sw[i0];
        cyc();
        add_hits(1);
        exp_moles[i0] = 1'b0;
        chk("hit1_score", 32'(score), 32'(exp_score));
        chk("hit1_moles", 32'(moles), 32'(exp_moles));
        sw[i0] = ~sw[i0];
        cyc();
        chk("rehit_score", 32'(score), 32'(exp_score));
        chk("rehit_moles", 32'(moles), 32'(exp_moles));
        whack();
        to_tick("t1");

        // Level climb: clear the board each tick, period shrinks by 2 per level
        cnt7 = 0;
        for (int it = 0; it < 80 && cnt7 < 2 && !over; it++) begin
            whack();
            to_tick("lvl");
            if (tick_level == 7 && period == 8) cnt7++;
        end
        chk("level_cap", 32'(level), 7);
        chk("lvl7_seen", 32'(cnt7), 2);

        // Hits landing on the tick edge itself count as hits, not misses
        n = 20 - 2 * (tick_level - 1);
        for (int k = 0; k < n - 1; k++) cyc();
        chk("pre_tick_quiet", 32'(tick), 0);
        pre = $countones(exp_moles);
        sw  = sw ^ exp_moles;
        cyc();
        add_hits(pre);
        tick_level = exp_level;
        exp_moles  = cur_pat;
        chk("edge_tick",   32'(tick),   1);
        chk("edge_score",  32'(score),  32'(exp_score));
        chk("edge_misses", 32'(misses), 32'(exp_miss));
        chk("edge_moles",  32'(moles),  32'(cur_pat));

        // Stop playing: misses pile up until the limit ends the game
        for (int it = 0; it < 20 && !over; it++) to_tick("miss");
        chk("miss_over", 32'(over), 1);
        sw = sw ^ 8'hFF;
        cyc();
        cyc();
        chk("over_score",  32'(score),  32'(exp_score));
        chk("over_level",  32'(level),  32'(exp_level));
        chk("over_misses", 32'(misses), 4);
        chk("over_moles",  32'(moles),  0);
        chk("over_tick",   32'(tick),   0);

        // Restart from OVER, then play until the score pins at 255
        do_start("restart");
        done = 1'b0;
        for (int it = 0; it < 200 && !done && !over; it++) begin
            pre = exp_score;
            whack();
            if (pre == 255) done = 1'b1;
            else            to_tick("sat");
        end
        chk("score_sat", 32'(score), 255);

        // Asynchronous reset in the middle of a tick
        cyc();
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        sw = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_reset("arst_hold");
        rst_n = 1'b1;
        cyc();
        cyc();
        do_start("post_rst");
        to_tick("post_rst_t");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
